sram_req_arbiter: RTL and testbench

- Shares a single SRAM-like slave port between the instruction-fetch master and the data (load/store) master.
- Picks one requester per address handshake.
- Records the owner of every accepted request in an in-order ownership FIFO, and routes each `data_ok`/`rdata` beat back to that owner.
- Sits between the IF/MEM stages and the bridge toward memory. Transparent pass-through: zero added cycles on the request and response paths.

---
 rtl/sram_req_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Two-master SRAM-like request arbiter with an in-order ownership FIFO for response routing.
// Optional build macro ARB_ROUND_ROBIN_EN selects alternating priority on conflicts (default: data-first).
module sram_req_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata,

  output logic        arb_busy
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW:0] DEPTH = (PW+1)'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                     state, state_nxt;
  logic                       lock_owner, lock_owner_nxt;
  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [PW-1:0]              rd_ptr, wr_ptr;
  logic [PW:0]                count;
  logic                       full, empty, head_owner;
  logic                       idle_grant, grant, want, push, pop;

  assign full       = (count == DEPTH);
  assign empty      = (count == '0);
  assign head_owner = owner_q[rd_ptr];

`ifdef ARB_ROUND_ROBIN_EN
  // Owner of the most recent accepted handshake (1 = data); the other master wins the next conflict.
  logic last_winner;

  always_ff @(posedge clk) begin
    if (!resetn)
      last_winner <= 1'b0;
    else if (push)
      last_winner <= grant;
  end

  assign idle_grant = (inst_sram_req & data_sram_req) ? ~last_winner : data_sram_req;
`else
  assign idle_grant = data_sram_req;
`endif

  always_comb begin
    state_nxt      = state;
    lock_owner_nxt = lock_owner;
    grant          = idle_grant;
    want           = inst_sram_req | data_sram_req;
    if (state == LOCKED) begin
      grant = lock_owner;
      want  = lock_owner ? data_sram_req : inst_sram_req;
    end

    sram_req = resetn & want & ~full;

    unique case (state)
      IDLE: begin
        if (sram_req && !sram_addr_ok) begin
          state_nxt      = LOCKED;
          lock_owner_nxt = grant;
        end
      end
      LOCKED: begin
        // A dropped request is a legal cancel before acceptance.
        if ((sram_req && sram_addr_ok) || !want)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push = sram_req & sram_addr_ok;
  assign pop  = sram_data_ok & ~empty;

  assign sram_wr    = sram_req & (grant ? data_sram_wr : inst_sram_wr);
  assign sram_size  = sram_req ? (grant ? data_sram_size  : inst_sram_size)  : '0;
  assign sram_wstrb = sram_req ? (grant ? data_sram_wstrb : inst_sram_wstrb) : '0;
  assign sram_addr  = sram_req ? (grant ? data_sram_addr  : inst_sram_addr)  : '0;
  assign sram_wdata = sram_req ? (grant ? data_sram_wdata : inst_sram_wdata) : '0;

  assign inst_sram_addr_ok = push & ~grant;
  assign data_sram_addr_ok = push &  grant;

  assign inst_sram_data_ok = resetn & pop & ~head_owner;
  assign data_sram_data_ok = resetn & pop &  head_owner;
  assign inst_sram_rdata   = resetn ? sram_rdata : '0;
  assign data_sram_rdata   = resetn ? sram_rdata : '0;

  assign arb_busy = resetn & ~empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      lock_owner <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      lock_owner <= lock_owner_nxt;
      if (push) begin
        owner_q[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized bench for sram_req_arbiter: a queue-based owner model predicts every output each cycle,
// plus directed sequences with literal expectations.
module tb_sram_req_arbiter;

  localparam int MAX = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        ireq, iwr, dreq, dwr;
  logic [1:0]  isize, dsize;
  logic [3:0]  iwstrb, dwstrb;
  logic [31:0] iaddr, iwdata, daddr, dwdata;
  logic        aok, dok;
  logic [31:0] rdata;

  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        busy;

  always #5 clk = ~clk;

  sram_req_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(ireq), .inst_sram_wr(iwr), .inst_sram_size(isize), .inst_sram_wstrb(iwstrb),
    .inst_sram_addr(iaddr), .inst_sram_wdata(iwdata),
    .inst_sram_addr_ok(i_addr_ok), .inst_sram_data_ok(i_data_ok), .inst_sram_rdata(i_rdata),
    .data_sram_req(dreq), .data_sram_wr(dwr), .data_sram_size(dsize), .data_sram_wstrb(dwstrb),
    .data_sram_addr(daddr), .data_sram_wdata(dwdata),
    .data_sram_addr_ok(d_addr_ok), .data_sram_data_ok(d_data_ok), .data_sram_rdata(d_rdata),
    .sram_req(s_req), .sram_wr(s_wr), .sram_size(s_size), .sram_wstrb(s_wstrb),
    .sram_addr(s_addr), .sram_wdata(s_wdata),
    .sram_addr_ok(aok), .sram_data_ok(dok), .sram_rdata(rdata),
    .arb_busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: owners of accepted requests in order, pending locked owner (-1 = none), last winner.
  bit oq[$];
  int lock = -1;
  bit lastw = 1'b0;
  bit e_req, e_grant, e_want;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic settle();
    bit full, pop, head;
    #3;
    full = (oq.size() >= MAX);
    if (lock >= 0) begin
      e_grant = lock[0];
      e_want  = e_grant ? dreq : ireq;
    end else begin
      e_want = ireq | dreq;
      if (ireq && dreq) e_grant = RR ? ~lastw : 1'b1;
      else              e_grant = dreq;
    end
    e_req = resetn && e_want && !full;
    pop   = resetn && dok && (oq.size() > 0);
    head  = (oq.size() > 0) ? oq[0] : 1'b0;
    check("sram_req",   {31'd0, s_req},   {31'd0, e_req});
    check("sram_wr",    {31'd0, s_wr},    e_req ? {31'd0, (e_grant ? dwr : iwr)} : 32'd0);
    check("sram_size",  {30'd0, s_size},  e_req ? {30'd0, (e_grant ? dsize : isize)} : 32'd0);
    check("sram_wstrb", {28'd0, s_wstrb}, e_req ? {28'd0, (e_grant ? dwstrb : iwstrb)} : 32'd0);
    check("sram_addr",  s_addr,  e_req ? (e_grant ? daddr : iaddr) : 32'd0);
    check("sram_wdata", s_wdata, e_req ? (e_grant ? dwdata : iwdata) : 32'd0);
    check("inst_addr_ok", {31'd0, i_addr_ok}, {31'd0, e_req && aok && !e_grant});
    check("data_addr_ok", {31'd0, d_addr_ok}, {31'd0, e_req && aok && e_grant});
    check("inst_data_ok", {31'd0, i_data_ok}, {31'd0, pop && !head});
    check("data_data_ok", {31'd0, d_data_ok}, {31'd0, pop && head});
    check("inst_rdata", i_rdata, resetn ? rdata : 32'd0);
    check("data_rdata", d_rdata, resetn ? rdata : 32'd0);
    check("arb_busy", {31'd0, busy}, {31'd0, resetn && (oq.size() > 0)});
  endtask

  task automatic tick();
    bit accepted;
    @(posedge clk);
    if (!resetn) begin
      oq.delete();
      lock  = -1;
      lastw = 1'b0;
    end else begin
      accepted = e_req && aok;
      if (dok && oq.size() > 0) void'(oq.pop_front());
      if (accepted) begin
        oq.push_back(e_grant);
        lastw = e_grant;
      end
      if (lock < 0) begin
        if (e_req && !aok) lock = int'(e_grant);
      end else if (accepted || !e_want) begin
        lock = -1;
      end
    end
    #1;
  endtask

  task automatic set_in(input bit ir, input bit dr, input bit a, input bit d, input logic [31:0] rd);
    ireq = ir; dreq = dr; aok = a; dok = d; rdata = rd;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    iwr = 1'b0; isize = 2'd2; iwstrb = 4'h0; iaddr = 32'h1c00_0000; iwdata = 32'h0;
    dwr = 1'b1; dsize = 2'd2; dwstrb = 4'hf; daddr = 32'h8000_0040; dwdata = 32'h1234_5678;
    set_in(1, 1, 1, 1, 32'hdead_beef);
    settle();
    check("reset_sram_req", {31'd0, s_req}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    tick();
    step();
    resetn = 1'b1;

    // Conflict: data wins first; inst accepted once data drops.
    set_in(1, 1, 1, 0, 0);
    settle();
    check("t1_data_addr_ok", {31'd0, d_addr_ok}, 32'd1);
    check("t1_inst_addr_ok", {31'd0, i_addr_ok}, 32'd0);
    tick();
    set_in(1, 0, 1, 0, 0);
    settle();
    check("t1_inst_after", {31'd0, i_addr_ok}, 32'd1);
    tick();
    set_in(0, 0, 0, 0, 0);
    settle();
    check("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    set_in(0, 0, 0, 1, 0);
    repeat (2) step();
    set_in(0, 0, 0, 0, 0);
    settle();
    check("t1_drained", {31'd0, busy}, 32'd0);
    tick();

    // Lock: inst presented, addr_ok low 3 cycles, data raised meanwhile.
    set_in(1, 0, 0, 0, 0);
    step();
    dreq = 1'b1;
    repeat (2) begin
      settle();
      check("t2_addr_locked", s_addr, 32'h1c00_0000);
      check("t2_no_data_ok", {31'd0, d_addr_ok}, 32'd0);
      tick();
    end
    aok = 1'b1;
    settle();
    check("t2_inst_accept", {31'd0, i_addr_ok}, 32'd1);
    check("t2_addr", s_addr, 32'h1c00_0000);
    tick();
    ireq = 1'b0;
    settle();
    check("t2_data_accept", {31'd0, d_addr_ok}, 32'd1);
    tick();
    set_in(0, 0, 0, 1, 0);
    repeat (2) step();

    // Fill to MAX, then a 5th request stalls until one response frees a slot.
    set_in(1, 0, 1, 0, 0);
    repeat (MAX) step();
    settle();
    check("t3_full_req", {31'd0, s_req}, 32'd0);
    check("t3_full_aok", {31'd0, i_addr_ok}, 32'd0);
    tick();
    dok = 1'b1;
    settle();
    check("t3_no_bypass", {31'd0, s_req}, 32'd0);
    tick();
    dok = 1'b0;
    settle();
    check("t3_unblocked", {31'd0, i_addr_ok}, 32'd1);
    tick();
    set_in(0, 0, 0, 1, 0);
    repeat (MAX) step();

    // Routing: issue inst, data, inst; responses A, B, C.
    set_in(1, 0, 1, 0, 0); step();
    set_in(0, 1, 1, 0, 0); step();
    set_in(1, 0, 1, 0, 0); step();
    set_in(0, 0, 0, 1, 32'hA);
    settle();
    check("t4_A_inst", {31'd0, i_data_ok}, 32'd1);
    check("t4_A_data", {31'd0, d_data_ok}, 32'd0);
    check("t4_A_rdata", i_rdata, 32'hA);
    tick();
    rdata = 32'hB;
    settle();
    check("t4_B_data", {31'd0, d_data_ok}, 32'd1);
    check("t4_B_inst", {31'd0, i_data_ok}, 32'd0);
    check("t4_B_rdata", d_rdata, 32'hB);
    tick();
    rdata = 32'hC;
    settle();
    check("t4_C_inst", {31'd0, i_data_ok}, 32'd1);
    check("t4_C_data", {31'd0, d_data_ok}, 32'd0);
    tick();
    settle();
    check("t4_spurious_i", {31'd0, i_data_ok}, 32'd0);
    check("t4_spurious_d", {31'd0, d_data_ok}, 32'd0);
    check("t4_spurious_busy", {31'd0, busy}, 32'd0);
    tick();

    // Reset with two outstanding.
    set_in(1, 0, 1, 0, 0);
    repeat (2) step();
    resetn = 1'b0;
    set_in(1, 1, 1, 1, 0);
    settle();
    check("t5_rst_req", {31'd0, s_req}, 32'd0);
    check("t5_rst_dok", {31'd0, i_data_ok}, 32'd0);
    tick();
    resetn = 1'b1;
    set_in(0, 0, 0, 0, 0);
    settle();
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_req", {31'd0, s_req}, 32'd0);
    tick();

`ifdef ARB_ROUND_ROBIN_EN
    set_in(1, 1, 1, 0, 0);
    for (int k = 0; k < MAX; k++) begin
      settle();
      check("rr_data", {31'd0, d_addr_ok}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_inst", {31'd0, i_addr_ok}, (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    set_in(0, 0, 0, 1, 0);
    repeat (MAX) step();
`endif

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      resetn = ($urandom_range(0, 199) != 0);
      ireq   = ($urandom_range(0, 9) < 6);
      dreq   = ($urandom_range(0, 9) < 5);
      aok    = $urandom_range(0, 1);
      dok    = ($urandom_range(0, 2) == 0);
      rdata  = $urandom;
      iwr = $urandom_range(0, 1); isize = 2'($urandom); iwstrb = 4'($urandom);
      iaddr = $urandom; iwdata = $urandom;
      dwr = $urandom_range(0, 1); dsize = 2'($urandom); dwstrb = 4'($urandom);
      daddr = $urandom; dwdata = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
